proc_mem_arbiter: RTL and testbench
===================================

# proc_mem_arbiter

Round-robin arbiter that shares one single-ported data memory between the `PROC_COUNT` SIMD processors dispatched by the command issuer. Each processor requests a burst (start address, length, read/write). The arbiter grants one owner at a time, drives the memory port for every beat with an auto-incrementing address, and routes read data back to the owner with a fixed 1-cycle memory latency. Bursts are non-preemptible once granted.

## Interface
Parameters:
- `PROC_COUNT`, default `` `PROC_COUNT `` (4): number of requesters; `PW = $clog2(PROC_COUNT)`.
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 32: memory data width.
- `LEN_W`, default 4: burst length field width; max burst is 2^LEN_W-1 beats.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rstn`  in  1  reset, synchronous, active-low.
- `i_req`  in  PROC_COUNT  per-processor burst request.
- `i_we`  in  PROC_COUNT  per-processor write (1) / read (0).
- `i_addr`  in  PROC_COUNT*ADDR_W  packed start addresses; proc k at `[k*ADDR_W +: ADDR_W]`.
- `i_len`  in  PROC_COUNT*LEN_W  packed beat counts; 0 means 1 beat.
- `i_wdata`  in  PROC_COUNT*DATA_W  packed write data; sampled only on granted beats.
- `o_gnt`  out  PROC_COUNT  one-hot; high on each cycle a beat of the owner's burst is issued.
- `o_rvalid`  out  PROC_COUNT  one-hot; read data valid for that processor.
- `o_rdata`  out  DATA_W  read data, shared by all processors; qualified by `o_rvalid`.
- `o_busy`  out  1  high while in BURST.
- `o_mem_en`  out  1  memory access strobe.
- `o_mem_we`  out  1  memory write enable.
- `o_mem_addr`  out  ADDR_W  memory address.
- `o_mem_wdata`  out  DATA_W  memory write data.
- `i_mem_rdata`  in  DATA_W  memory read data; valid 1 cycle after a read strobe.

## Operation
- States: IDLE, BURST.
- IDLE:
  - If `i_req != 0`, select the winner as the first set bit searching upward from `last_owner+1`, wrapping modulo PROC_COUNT.
  - Latch the winner's `owner`, `we`, base `addr`, and `len` (0 forced to 1). Clear the beat counter. Go to BURST.
  - With no request, stay in IDLE.
- BURST, one beat per cycle:
  - `o_mem_en`=1, `o_mem_we`=latched we, `o_mem_addr`=(base+beat) mod 2^ADDR_W.
  - `o_mem_wdata`=owner's `i_wdata` slice, combinational.
  - `o_gnt`=1<<owner.
  - On the beat where beat==len-1: set `last_owner`<=owner and go to IDLE. Otherwise beat<=beat+1.
- Read return: register `rd_pending`=en&~we and `rd_owner`. The next cycle, `o_rvalid`=rd_pending<<rd_owner and `o_rdata`=`i_mem_rdata`.
- Request lines are sampled only in IDLE.
  - Deasserting `i_req` mid-burst does not stop the burst.
  - A still-asserted `i_req` after a burst completes is a new request.
- All memory-side outputs and `o_gnt` are 0 in IDLE.
- Reset (synchronous, any state, including mid-burst):
  - State=IDLE and `last_owner`=PROC_COUNT-1, so processor 0 wins first.
  - beat=0, `rd_pending`=0.
  - All outputs are 0 in the cycle after the reset edge.
  - An aborted burst produces no further `o_gnt` or `o_rvalid`.

## Timing
- Request seen in IDLE at edge t: BURST during cycles t+1..t+N. `o_gnt` and `o_mem_en` are high for exactly N consecutive cycles.
- IDLE returns at t+N+1. That cycle is the arbitration cycle, and the next burst starts at t+N+2.
- Bubble: exactly 1 idle memory cycle between back-to-back bursts.
- Read data: `o_rvalid` for beat i is at cycle t+2+i. The last beat's `o_rvalid` falls in the following IDLE cycle.
- Write data must be valid in the same cycle as the corresponding `o_gnt`.
- Fairness: with all requests held, every processor is granted once within PROC_COUNT bursts.

## Test plan
- Reset: hold `i_rstn`=0 with random inputs -> all outputs 0. Release with `i_req`=4'b1111 -> processor 0 granted first.
- Write burst: proc 1, addr 0x0010, len 3, wdata 0xA0/0xA1/0xA2 on successive gnt cycles.
  - Expect mem writes 0x0010=0xA0, 0x0011=0xA1, 0x0012=0xA2.
  - `o_gnt`=4'b0010 for 3 cycles, then 0.
- Read burst: proc 2, addr 0x0100, len 2, memory preloaded 0x11, 0x22 -> `o_rvalid`=4'b0100 at t+2 with 0x11 and at t+3 with 0x22.
- Round-robin: all four request len 1 continuously -> grant order 0,1,2,3,0, with one bubble between each.
- Edge cases:
  - Addr 0xFFFE, len 4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - len 0 -> exactly 1 beat.
- Reset mid-burst: proc 3 len 8, assert `i_rstn`=0 after beat 2 -> no further gnt/rvalid. After release, proc 0 wins over a simultaneous proc 3.

Source files
------------

// File: rtl/proc_mem_arbiter.sv
// Round-robin burst arbiter sharing one single-ported data memory between
// PROC_COUNT processors. One owner per burst, one beat per cycle, reads
// return one cycle after the strobe.
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

module proc_mem_arbiter #(
   parameter int unsigned PROC_COUNT = `PROC_COUNT,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned LEN_W      = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rstn,
   input  logic [PROC_COUNT-1:0]        i_req,
   input  logic [PROC_COUNT-1:0]        i_we,
   input  logic [PROC_COUNT*ADDR_W-1:0] i_addr,
   input  logic [PROC_COUNT*LEN_W-1:0]  i_len,
   input  logic [PROC_COUNT*DATA_W-1:0] i_wdata,
   output logic [PROC_COUNT-1:0]        o_gnt,
   output logic [PROC_COUNT-1:0]        o_rvalid,
   output logic [DATA_W-1:0]            o_rdata,
   output logic                         o_busy,
   output logic                         o_mem_en,
   output logic                         o_mem_we,
   output logic [ADDR_W-1:0]            o_mem_addr,
   output logic [DATA_W-1:0]            o_mem_wdata,
   input  logic [DATA_W-1:0]            i_mem_rdata
);

   localparam int unsigned PW = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

   typedef enum logic {
      S_IDLE,
      S_BURST
   } state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      owner_q, owner_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   beat_q, beat_d;
   logic [PW-1:0]      last_owner_q, last_owner_d;
   logic               rd_pending_q, rd_pending_d;
   logic [PW-1:0]      rd_owner_q, rd_owner_d;

   logic               found;
   logic [PW-1:0]      winner;
   logic [LEN_W-1:0]   win_len;
   logic               busy;

   // State and burst-context registers; reset may land mid-burst.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q      <= S_IDLE;
         owner_q      <= '0;
         we_q         <= 1'b0;
         base_q       <= '0;
         len_q        <= '0;
         beat_q       <= '0;
         last_owner_q <= PW'(PROC_COUNT - 1);
         rd_pending_q <= 1'b0;
         rd_owner_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         base_q       <= base_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         last_owner_q <= last_owner_d;
         rd_pending_q <= rd_pending_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   // Round-robin winner: first request at or above last_owner+1, wrapping.
   always_comb begin
      int unsigned cand;
      found  = 1'b0;
      winner = '0;
      cand   = 0;
      for (int unsigned i = 0; i < PROC_COUNT; i++) begin
         cand = (32'(last_owner_q) + 32'd1 + i) % PROC_COUNT;
         if (!found && i_req[PW'(cand)]) begin
            found  = 1'b1;
            winner = PW'(cand);
         end
      end
      win_len = i_len[winner*LEN_W +: LEN_W];
   end

   // Next-state: latch burst context in IDLE, count beats in BURST.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      base_d       = base_q;
      len_d        = len_q;
      beat_d       = beat_q;
      last_owner_d = last_owner_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_BURST;
               owner_d = winner;
               we_d    = i_we[winner];
               base_d  = i_addr[winner*ADDR_W +: ADDR_W];
               len_d   = (win_len == '0) ? LEN_W'(1) : win_len;
               beat_d  = '0;
            end
         end
         S_BURST: begin
            if (beat_q == len_q - LEN_W'(1)) begin
               state_d      = S_IDLE;
               last_owner_d = owner_q;
            end else begin
               beat_d = beat_q + LEN_W'(1);
            end
         end
      endcase
   end

   // Memory port, grants and read-return routing, all zero outside a burst.
   always_comb begin
      busy         = (state_q == S_BURST);
      rd_pending_d = busy & ~we_q;
      rd_owner_d   = owner_q;
      o_busy       = busy;
      o_mem_en     = busy;
      o_mem_we     = busy & we_q;
      o_mem_addr   = busy ? (base_q + ADDR_W'(beat_q)) : '0;
      o_mem_wdata  = busy ? i_wdata[owner_q*DATA_W +: DATA_W] : '0;
      o_gnt        = busy ? (PROC_COUNT'(1) << owner_q) : '0;
      o_rvalid     = rd_pending_q ? (PROC_COUNT'(1) << rd_owner_q) : '0;
      o_rdata      = rd_pending_q ? i_mem_rdata : '0;
   end

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed bench for proc_mem_arbiter with a 1-cycle-latency memory model.
module tb_proc_mem_arbiter;

   localparam int unsigned P  = 4;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 4;

   logic            clk = 1'b0;
   logic            rstn;
   logic [P-1:0]    req, we;
   logic [P*AW-1:0] addr;
   logic [P*LW-1:0] len;
   logic [P*DW-1:0] wdata;
   logic [P-1:0]    gnt, rvalid;
   logic [DW-1:0]   rdata;
   logic            busy, mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata = '0;

   logic            pl_en = 1'b0;
   logic [AW-1:0]   pl_addr = '0;
   logic [DW-1:0]   pl_data = '0;
   logic [DW-1:0]   mem [0:65535];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   proc_mem_arbiter #(.PROC_COUNT(P), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_we(we), .i_addr(addr),
      .i_len(len), .i_wdata(wdata), .o_gnt(gnt), .o_rvalid(rvalid),
      .o_rdata(rdata), .o_busy(busy), .o_mem_en(mem_en), .o_mem_we(mem_we),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   // Single-ported memory: writes and reads on the edge, read data next cycle.
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_gnt"},    64'(gnt),       64'd0);
      check({tag, "_rvalid"}, 64'(rvalid),    64'd0);
      check({tag, "_rdata"},  64'(rdata),     64'd0);
      check({tag, "_busy"},   64'(busy),      64'd0);
      check({tag, "_en"},     64'(mem_en),    64'd0);
      check({tag, "_we"},     64'(mem_we),    64'd0);
      check({tag, "_addr"},   64'(mem_addr),  64'd0);
      check({tag, "_wdata"},  64'(mem_wdata), 64'd0);
   endtask

   initial begin
      // Reset with random inputs: everything must stay quiet.
      rstn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req   = P'($urandom);
         we    = P'($urandom);
         addr  = {$urandom, $urandom};
         len   = P*LW'($urandom);
         wdata = {$urandom, $urandom, $urandom, $urandom};
         tick();
         check_quiet("rst");
      end

      // Release with all requesting: processor 0 first.
      req = 4'b1111; we = 4'b0000; len = '0; wdata = '0;
      rstn = 1'b1;
      tick();
      check("rst_first_gnt", 64'(gnt), 64'h1);
      req = 4'b0000;
      tick();
      check("rst_first_end", 64'(gnt), 64'h0);
      check("rst_first_rv",  64'(rvalid), 64'h1);

      // Write burst: proc 1, 0x0010, 3 beats.
      addr[1*AW +: AW] = 16'h0010; len[1*LW +: LW] = 4'd3; we = 4'b0010; req = 4'b0010;
      tick();
      req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         wdata[1*DW +: DW] = 32'hA0 + 32'(i);
         #1;
         check("wr_gnt",   64'(gnt),       64'h2);
         check("wr_we",    64'(mem_we),    64'h1);
         check("wr_addr",  64'(mem_addr),  64'h10 + 64'(i));
         check("wr_wdata", 64'(mem_wdata), 64'hA0 + 64'(i));
         tick();
      end
      check("wr_end_gnt",  64'(gnt),  64'h0);
      check("wr_end_busy", 64'(busy), 64'h0);
      check("wr_mem10", 64'(mem[16'h0010]), 64'hA0);
      check("wr_mem11", 64'(mem[16'h0011]), 64'hA1);
      check("wr_mem12", 64'(mem[16'h0012]), 64'hA2);

      // Read burst: proc 2, 0x0100, 2 beats, preloaded 0x11/0x22.
      pl_en = 1'b1; pl_addr = 16'h0100; pl_data = 32'h11;
      tick();
      pl_addr = 16'h0101; pl_data = 32'h22;
      tick();
      pl_en = 1'b0;
      addr[2*AW +: AW] = 16'h0100; len[2*LW +: LW] = 4'd2; we = 4'b0000; req = 4'b0100;
      tick();
      req = 4'b0000;
      check("rd_b0_gnt",  64'(gnt),      64'h4);
      check("rd_b0_addr", 64'(mem_addr), 64'h100);
      check("rd_b0_we",   64'(mem_we),   64'h0);
      check("rd_b0_rv",   64'(rvalid),   64'h0);
      tick();
      check("rd_b1_addr", 64'(mem_addr), 64'h101);
      check("rd_b1_rv",   64'(rvalid),   64'h4);
      check("rd_b1_data", 64'(rdata),    64'h11);
      tick();
      check("rd_end_gnt", 64'(gnt),    64'h0);
      check("rd_end_rv",  64'(rvalid), 64'h4);
      check("rd_end_data",64'(rdata),  64'h22);
      tick();
      check("rd_after_rv", 64'(rvalid), 64'h0);

      // Round-robin from reset: 0,1,2,3,0 with one bubble each.
      rstn = 1'b0;
      tick();
      rstn = 1'b1; len = '0; we = 4'b0000; req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_gnt", 64'(gnt), 64'(1) << (k % 4));
         if (k == 4) req = 4'b0000;
         tick();
         check("rr_bubble", 64'(gnt), 64'h0);
         check("rr_rv", 64'(rvalid), 64'(1) << (k % 4));
      end

      // Address wrap: proc 1, 0xFFFE, 4 beats.
      addr[1*AW +: AW] = 16'hFFFE; len[1*LW +: LW] = 4'd4; we = 4'b0010;
      wdata[1*DW +: DW] = 32'h55; req = 4'b0010;
      tick();
      req = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         check("wrap_gnt",  64'(gnt),      64'h2);
         check("wrap_addr", 64'(mem_addr), 64'(16'(32'hFFFE + 32'(i))));
         tick();
      end
      check("wrap_end_gnt", 64'(gnt), 64'h0);
      check("wrap_memffff", 64'(mem[16'hFFFF]), 64'h55);
      check("wrap_mem0001", 64'(mem[16'h0001]), 64'h55);

      // len 0 means exactly one beat.
      len[3*LW +: LW] = 4'd0; we = 4'b0000; req = 4'b1000;
      tick();
      req = 4'b0000;
      check("len0_gnt", 64'(gnt),    64'h8);
      check("len0_en",  64'(mem_en), 64'h1);
      tick();
      check("len0_end_gnt",  64'(gnt),    64'h0);
      check("len0_end_busy", 64'(busy),   64'h0);

      // Reset mid-burst: proc 3, 8-beat read, reset during beat 2.
      addr[3*AW +: AW] = 16'h0200; len[3*LW +: LW] = 4'd8; we = 4'b0000; req = 4'b1000;
      tick();
      req = 4'b0000;
      tick();
      tick();
      check("mid_b2_gnt",  64'(gnt),      64'h8);
      check("mid_b2_addr", 64'(mem_addr), 64'h202);
      rstn = 1'b0;
      tick();
      check_quiet("mid_rst");
      tick();
      check_quiet("mid_rst2");
      rstn = 1'b1; len = '0; req = 4'b1001;
      tick();
      check("mid_rel_gnt", 64'(gnt), 64'h1);
      req = 4'b0000;
      tick();
      check("mid_rel_end", 64'(gnt), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
